// File: rtl/gameplay_pkg.sv
// Shared encodings and playfield constants for the block-stacking game control.
// Optional feature macro used by importers: RANDOM_SPAWN_EN.
package gameplay_pkg;

    localparam logic [6:0] TOP_Y    = 7'd8;
    localparam logic [6:0] FLOOR_Y  = 7'd112;
    localparam logic [6:0] BLOCK_H  = 7'd4;
    localparam logic [7:0] SCREEN_W = 8'd160;

    // Random spawn x is folded into 0..151 so a block always fits on screen.
    localparam logic [7:0] SPAWN_RANGE = 8'd152;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SPAWN     = 4'd1;
    localparam logic [3:0] S_SWING     = 4'd2;
    localparam logic [3:0] S_DROP      = 4'd3;
    localparam logic [3:0] S_WAIT_O    = 4'd4;
    localparam logic [3:0] S_CHECK     = 4'd5;
    localparam logic [3:0] S_HIT       = 4'd6;
    localparam logic [3:0] S_MISS      = 4'd7;
    localparam logic [3:0] S_GAME_OVER = 4'd8;

    function automatic logic [7:0] fold_spawn_x(input logic [7:0] v);
        return (v >= SPAWN_RANGE) ? (v - SPAWN_RANGE) : v;
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying random spawn x/direction.
// Only instantiated when RANDOM_SPAWN_EN is defined.
module spawn_lfsr
    import gameplay_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/block_drop_control.sv
// Control FSM for the block-stacking game: spawn, swing, drop, overlap check, scoring.
// Define RANDOM_SPAWN_EN to take spawn x/direction from spawn_lfsr instead of SPAWN_X/dir_reg.
module block_drop_control
    import gameplay_pkg::*;
#(
    parameter logic [7:0] SPAWN_X   = 8'd0,
    parameter logic [6:0] DROP_STEP = 7'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       drop,
    input  logic       tick,
    input  logic       o,
    input  logic       c,
    output logic       enable,
    output logic       save_x,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_d,
    output logic       inc_score,
    output logic       dec_chances,
    output logic       new_direction,
    output logic [7:0] new_x_position,
    output logic [6:0] new_y_position,
    output logic       game_over
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [6:0] land_y;
    logic [6:0] y_cur;
    logic [5:0] stack_cnt;
    logic       dir_reg;
    logic       drop_q;

    logic       drop_rise;
    logic [7:0] y_sum;
    logic       landed;
    logic [6:0] y_step;
    logic [6:0] land_after_hit;
    logic       stack_full;

    assign drop_rise = drop & ~drop_q;

    // Sum is one bit wider so the landing compare cannot wrap near the floor.
    assign y_sum          = {1'b0, y_cur} + {1'b0, DROP_STEP};
    assign landed         = (y_sum >= {1'b0, land_y});
    assign y_step         = landed ? land_y : y_sum[6:0];
    assign land_after_hit = land_y - BLOCK_H;
    assign stack_full     = ((land_after_hit - BLOCK_H) <= TOP_Y);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_SPAWN;
            S_SPAWN:     state_nxt = c ? S_SWING : S_GAME_OVER;
            S_SWING:     if (drop_rise) state_nxt = S_DROP;
            S_DROP:      if (tick && landed) state_nxt = S_WAIT_O;
            S_WAIT_O:    state_nxt = S_CHECK;
            S_CHECK:     state_nxt = ((stack_cnt == 6'd0) || o) ? S_HIT : S_MISS;
            S_HIT:       state_nxt = stack_full ? S_GAME_OVER : S_SPAWN;
            S_MISS:      state_nxt = S_SPAWN;
            S_GAME_OVER: if (start) state_nxt = S_SPAWN;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            land_y    <= FLOOR_Y;
            y_cur     <= TOP_Y;
            stack_cnt <= 6'd0;
            dir_reg   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= drop;
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        land_y    <= FLOOR_Y;
                        stack_cnt <= 6'd0;
                    end
                end
                S_SPAWN: y_cur <= TOP_Y;
                S_DROP: begin
                    if (tick) y_cur <= y_step;
                end
                S_HIT: begin
                    stack_cnt <= stack_cnt + 6'd1;
                    land_y    <= land_after_hit;
                    dir_reg   <= ~dir_reg;
                end
                default: ;
            endcase
        end
    end

    // ld_y in DROP is gated by tick so each frame pulse moves the block exactly once.
    assign enable         = (state == S_SWING);
    assign save_x         = (state == S_HIT);
    assign inc_score      = (state == S_HIT);
    assign ld_x           = (state == S_SPAWN);
    assign ld_d           = (state == S_SPAWN);
    assign ld_y           = (state == S_SPAWN) || ((state == S_DROP) && tick);
    assign dec_chances    = (state == S_MISS);
    assign game_over      = (state == S_GAME_OVER);
    assign new_y_position = (state == S_DROP) ? y_step : TOP_Y;

`ifdef RANDOM_SPAWN_EN
    logic [7:0] lfsr_value;

    spawn_lfsr u_spawn_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    assign new_x_position = fold_spawn_x(lfsr_value);
    assign new_direction  = lfsr_value[0];
`else
    assign new_x_position = SPAWN_X;
    assign new_direction  = dir_reg;
`endif

endmodule

// File: tb/tb_block_drop_control.sv
// Directed bench for block_drop_control: vector table for start-up, hand sequences for drops,
// misses, game over, reset mid-drop and a full 25-block stack.
module tb_block_drop_control;
    import gameplay_pkg::*;

    localparam logic [8:0] F_EN  = 9'b100000000;
    localparam logic [8:0] F_SV  = 9'b010000000;
    localparam logic [8:0] F_LX  = 9'b001000000;
    localparam logic [8:0] F_LY  = 9'b000100000;
    localparam logic [8:0] F_LD  = 9'b000010000;
    localparam logic [8:0] F_INC = 9'b000001000;
    localparam logic [8:0] F_DEC = 9'b000000100;
    localparam logic [8:0] F_DIR = 9'b000000010;
    localparam logic [8:0] F_GO  = 9'b000000001;
    localparam logic [8:0] F_SPAWN = F_LX | F_LY | F_LD;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, drop, tick, o, c;
    logic       enable, save_x, ld_x, ld_y, ld_d, inc_score, dec_chances;
    logic       new_direction, game_over;
    logic [7:0] new_x_position;
    logic [6:0] new_y_position;

    int         total = 0;
    int         bad = 0;
    logic       exp_dir = 1'b0;
    logic [6:0] exp_q[$];

    typedef struct {
        string      name;
        logic       start, drop, tick, o, c;
        logic [8:0] flags;
        logic [6:0] y;
    } vec_t;

    vec_t tbl[8];

    block_drop_control dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .drop           (drop),
        .tick           (tick),
        .o              (o),
        .c              (c),
        .enable         (enable),
        .save_x         (save_x),
        .ld_x           (ld_x),
        .ld_y           (ld_y),
        .ld_d           (ld_d),
        .inc_score      (inc_score),
        .dec_chances    (dec_chances),
        .new_direction  (new_direction),
        .new_x_position (new_x_position),
        .new_y_position (new_y_position),
        .game_over      (game_over)
    );

    always #10 clk = ~clk;

    function automatic logic [23:0] outs();
        return {enable, save_x, ld_x, ld_y, ld_d, inc_score, dec_chances,
                new_direction, game_over, new_x_position, new_y_position};
    endfunction

    function automatic logic [23:0] mk(input logic [8:0] flags, input logic [6:0] y);
        return {flags, 8'd0, y};
    endfunction

    function automatic logic [8:0] dirf();
        return exp_dir ? F_DIR : 9'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, then let combinational outputs settle before sampling.
    task automatic step(input logic s, input logic d, input logic t, input logic ov, input logic cv);
        @(negedge clk);
        start = s; drop = d; tick = t; o = ov; c = cv;
        #1;
    endtask

    task automatic spawn_step(input logic cv);
        step(1'b0, 1'b0, 1'b0, 1'b0, cv);
        chk("spawn", {8'd0, outs()}, {8'd0, mk(F_SPAWN | dirf(), TOP_Y)});
    endtask

    task automatic go_step(input logic s);
        step(s, s, 1'b1, 1'b0, 1'b1);
        chk("game_over", {8'd0, outs()}, {8'd0, mk(F_GO | dirf(), TOP_Y)});
    endtask

    // Starts in SWING: drop edge, tick every cycle until landing, then CHECK and HIT/MISS.
    task automatic do_block(input logic [6:0] land, input logic ov, input logic hit);
        logic       done;
        logic [6:0] ey;
        for (int v = int'(TOP_Y) + 1; v <= int'(land); v++) exp_q.push_back(7'(v));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("swing", {8'd0, outs()}, {8'd0, mk(F_EN | dirf(), TOP_Y)});
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (ld_y) begin
                ey = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
                chk("drop_y", {8'd0, outs()}, {8'd0, mk(F_LY | dirf(), ey)});
            end else begin
                done = 1'b1;
                chk("wait_o", {8'd0, outs()}, {8'd0, mk(dirf(), TOP_Y)});
            end
        end
        chk("drop_done", {31'd0, done}, 32'd1);
        chk("drop_count", exp_q.size(), 32'd0);
        exp_q.delete();
        step(1'b0, 1'b0, 1'b0, ov, 1'b1);
        chk("check", {8'd0, outs()}, {8'd0, mk(dirf(), TOP_Y)});
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (hit) begin
            chk("hit", {8'd0, outs()}, {8'd0, mk(F_SV | F_INC | dirf(), TOP_Y)});
            exp_dir = ~exp_dir;
        end else begin
            chk("miss", {8'd0, outs()}, {8'd0, mk(F_DEC | dirf(), TOP_Y)});
        end
    endtask

    initial begin
        tbl[0] = '{"reset_idle",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0,    TOP_Y};
        tbl[1] = '{"start_pulse",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0,    TOP_Y};
        tbl[2] = '{"first_spawn",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_SPAWN, TOP_Y};
        tbl[3] = '{"first_swing",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_EN,    TOP_Y};
        tbl[4] = '{"swing_tick_edge", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, F_EN, TOP_Y};
        tbl[5] = '{"drop_no_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0,    7'd9};
        tbl[6] = '{"drop_tick1",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, F_LY,    7'd9};
        tbl[7] = '{"drop_tick2",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, F_LY,    7'd10};

        reset = 1'b1;
        start = 1'b0; drop = 1'b0; tick = 1'b0; o = 1'b0; c = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Start-up, SPAWN strobes, simultaneous tick and drop edge in SWING.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].start, tbl[i].drop, tbl[i].tick, tbl[i].o, tbl[i].c);
            chk(tbl[i].name, {8'd0, outs()}, {8'd0, mk(tbl[i].flags, tbl[i].y)});
        end
        for (int y = 11; y <= 112; y++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("first_drop_y", {8'd0, outs()}, {8'd0, mk(F_LY, 7'(y))});
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("first_wait_o", {8'd0, outs()}, {8'd0, mk(9'd0, TOP_Y)});
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("first_check", {8'd0, outs()}, {8'd0, mk(9'd0, TOP_Y)});
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_hit", {8'd0, outs()}, {8'd0, mk(F_SV | F_INC, TOP_Y)});
        exp_dir = 1'b1;

        // Second and third blocks miss; landing stays at 108 both times.
        spawn_step(1'b1);
        do_block(7'd108, 1'b0, 1'b0);
        spawn_step(1'b1);
        do_block(7'd108, 1'b0, 1'b0);

        // Out of chances: SPAWN with c=0 goes to GAME_OVER, inputs other than start ignored.
        spawn_step(1'b0);
        go_step(1'b0);
        go_step(1'b0);
        go_step(1'b1);

        // Restart: floor restored, first block hits regardless of o.
        spawn_step(1'b1);
        do_block(7'd112, 1'b0, 1'b1);

        // start mid-game ignored; drop held high gives a single DROP entry.
        spawn_step(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("start_mid_game", {8'd0, outs()}, {8'd0, mk(F_EN | dirf(), TOP_Y)});
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("held_drop_edge", {8'd0, outs()}, {8'd0, mk(F_EN | dirf(), TOP_Y)});
        for (int i = 0; i < 49; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            chk("held_drop_stay", {8'd0, outs()}, {8'd0, mk(dirf(), 7'd9)});
        end

        // Asynchronous reset mid-DROP, then no strobes until start.
        @(negedge clk);
        tick = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_reset", {8'd0, outs()}, {8'd0, mk(9'd0, TOP_Y)});
        exp_dir = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'(i % 2), 1'b1, 1'b1, 1'b1);
            chk("post_reset_quiet", {8'd0, outs()}, {8'd0, mk(9'd0, TOP_Y)});
        end

        // 25 hits fill the screen; the last HIT goes straight to GAME_OVER.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_idle", {8'd0, outs()}, {8'd0, mk(9'd0, TOP_Y)});
        for (int k = 0; k < 25; k++) begin
            spawn_step(1'b1);
            do_block(7'(112 - 4 * k), 1'b1, 1'b1);
        end
        go_step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
